// File: rtl/bpu_recovery_ctrl.sv
// Branch-prediction recovery controller: queues fetch-time predictions in order,
// checks the oldest against the execute-stage outcome and flushes on a mismatch.
module bpu_recovery_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pred_valid_i,
    output logic                     pred_ready_o,
    input  logic [31:0]              pred_pc_i,
    input  logic                     pred_taken_i,
    input  logic [31:0]              pred_addr_i,
    input  logic                     res_valid_i,
    input  logic                     res_taken_i,
    input  logic [31:0]              res_addr_i,
    output logic                     flush_o,
    output logic [31:0]              redirect_addr_o,
    output logic                     hold_o,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic [31:0]              branch_cnt_o,
    output logic [31:0]              mispred_cnt_o,
    output logic                     res_error_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] addr;
    } rec_t;

    state_t        state_reg, state_next;
    rec_t          mem [DEPTH];
    rec_t          head;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [31:0]   redirect_reg;
    logic [31:0]   branch_cnt_reg;
    logic [31:0]   mispred_cnt_reg;
    logic          res_error_reg;

    logic push;
    logic pop;
    logic mismatch;

    // The head must be compared in the same cycle the resolve arrives, so the
    // record store is read asynchronously.
    assign head = mem[rd_ptr_reg];

    assign push     = pred_valid_i && pred_ready_o;
    assign pop      = (state_reg == RUN) && res_valid_i && (count_reg != '0);
    assign mismatch = pop && ((res_taken_i != head.taken) ||
                              (res_taken_i && (res_addr_i != head.addr)));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= '{pc: pred_pc_i, taken: pred_taken_i, addr: pred_addr_i};
        end
    end

    // A mispredicted head invalidates everything younger, including a same-cycle push.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (mismatch) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
            case ({push, pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (mismatch) state_next = FLUSH;
            FLUSH:   state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        flush_o      = (state_reg == FLUSH);
        pred_ready_o = (state_reg == RUN) && (count_reg < DEPTH_C);
        hold_o       = (count_reg == DEPTH_C);
        occupancy_o  = count_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            redirect_reg    <= '0;
            branch_cnt_reg  <= '0;
            mispred_cnt_reg <= '0;
            res_error_reg   <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            if (mismatch) begin
                redirect_reg <= res_taken_i ? res_addr_i : (head.pc + 32'd4);
            end
            if (pop && (branch_cnt_reg != '1)) begin
                branch_cnt_reg <= branch_cnt_reg + 32'd1;
            end
            if (mismatch && (mispred_cnt_reg != '1)) begin
                mispred_cnt_reg <= mispred_cnt_reg + 32'd1;
            end
            if ((state_reg == RUN) && res_valid_i && (count_reg == '0)) begin
                res_error_reg <= 1'b1;
            end
        end
    end

    assign redirect_addr_o = redirect_reg;
    assign branch_cnt_o    = branch_cnt_reg;
    assign mispred_cnt_o   = mispred_cnt_reg;
    assign res_error_o     = res_error_reg;

endmodule
